// File: rtl/mult_share_arbiter.sv
// Round-robin share of one external combinational multiplier between two
// valid/ready requesters. Operands are held on mul_a/mul_b for MUL_LAT cycles,
// then mul_p is registered into the granted requester's response channel.
module mult_share_arbiter #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               resp0_valid,
    input  logic               resp0_ready,
    output logic [2*WIDTH-1:0] resp0_data,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               resp1_valid,
    input  logic               resp1_ready,
    output logic [2*WIDTH-1:0] resp1_data,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic [2*WIDTH-1:0] mul_p,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    localparam int unsigned PW = 2 * WIDTH;
    // Settle counter needs at least one bit even when MUL_LAT is 1.
    localparam int unsigned SW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [SW-1:0] SettleInit = SW'(MUL_LAT - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             gnt_q, gnt_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic             resp0_valid_q, resp0_valid_d;
    logic             resp1_valid_q, resp1_valid_d;
    logic [PW-1:0]    resp0_data_q, resp0_data_d;
    logic [PW-1:0]    resp1_data_q, resp1_data_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic any_req;
    logic sel;
    logic resp_ack;

    // Arbitration: pointer only breaks ties; a lone requester always wins.
    always_comb begin
        any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            sel = ptr_q;
        end else begin
            sel = req1_valid;
        end
    end

    // Next-state, operand capture, response and ready generation.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        gnt_d         = gnt_q;
        cnt_d         = cnt_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        resp0_valid_d = resp0_valid_q;
        resp1_valid_d = resp1_valid_q;
        resp0_data_d  = resp0_data_q;
        resp1_data_d  = resp1_data_q;
        op_count_d    = op_count_q;
        req0_ready    = 1'b0;
        req1_ready    = 1'b0;
        resp_ack      = 1'b0;

        case (state_q)
            StIdle: begin
                // Ready is masked while reset is held so no handshake is implied.
                req0_ready = any_req & ~sel & ~rst;
                req1_ready = any_req & sel & ~rst;
                if (any_req) begin
                    mul_a_d = sel ? req1_a : req0_a;
                    mul_b_d = sel ? req1_b : req0_b;
                    gnt_d   = sel;
                    cnt_d   = SettleInit;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - SW'(1);
                end else begin
                    if (gnt_q) begin
                        resp1_data_d  = mul_p;
                        resp1_valid_d = 1'b1;
                    end else begin
                        resp0_data_d  = mul_p;
                        resp0_valid_d = 1'b1;
                    end
                    state_d = StResp;
                end
            end
            StResp: begin
                resp_ack = gnt_q ? resp1_ready : resp0_ready;
                if (resp_ack) begin
                    resp0_valid_d = 1'b0;
                    resp1_valid_d = 1'b0;
                    op_count_d    = op_count_q + CNT_W'(1);
                    ptr_d         = ~gnt_q;
                    state_d       = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            ptr_q         <= 1'b0;
            gnt_q         <= 1'b0;
            cnt_q         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            resp0_data_q  <= '0;
            resp1_data_q  <= '0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            cnt_q         <= cnt_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
            resp0_data_q  <= resp0_data_d;
            resp1_data_q  <= resp1_data_d;
            op_count_q    <= op_count_d;
        end
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign resp0_valid = resp0_valid_q;
    assign resp1_valid = resp1_valid_q;
    assign resp0_data  = resp0_data_q;
    assign resp1_data  = resp1_data_q;
    assign op_count    = op_count_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter. Inputs are driven on the falling edge
// and outputs sampled 1 time unit later. Cycle c is the negedge-to-negedge slot
// in which stimulus is applied; a grant in cycle c yields resp_valid in cycle
// c+MUL_LAT+1.
module tb_mult_share_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic [4:0] req0_a, req0_b;
    logic [9:0] resp0_data;
    logic       req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [4:0] req1_a, req1_b;
    logic [9:0] resp1_data;
    logic [4:0] mul_a, mul_b;
    logic [9:0] mul_p;
    logic       busy;
    logic [7:0] op_count;

    // Second instance with a three-cycle settle time.
    logic       l3_req0_valid, l3_req0_ready, l3_resp0_valid, l3_resp0_ready;
    logic [4:0] l3_req0_a, l3_req0_b;
    logic [9:0] l3_resp0_data;
    logic       l3_req1_ready, l3_resp1_valid;
    logic [9:0] l3_resp1_data;
    logic [4:0] l3_mul_a, l3_mul_b;
    logic [9:0] l3_mul_p;
    logic       l3_busy;
    logic [7:0] l3_op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Models of the external combinational multipliers.
    assign mul_p    = 10'(mul_a) * 10'(mul_b);
    assign l3_mul_p = 10'(l3_mul_a) * 10'(l3_mul_b);

    mult_share_arbiter #(.WIDTH(5), .MUL_LAT(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .busy(busy), .op_count(op_count)
    );

    mult_share_arbiter #(.WIDTH(5), .MUL_LAT(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(l3_req0_valid), .req0_ready(l3_req0_ready),
        .req0_a(l3_req0_a), .req0_b(l3_req0_b),
        .resp0_valid(l3_resp0_valid), .resp0_ready(l3_resp0_ready),
        .resp0_data(l3_resp0_data),
        .req1_valid(1'b0), .req1_ready(l3_req1_ready),
        .req1_a(5'd0), .req1_b(5'd0),
        .resp1_valid(l3_resp1_valid), .resp1_ready(1'b1), .resp1_data(l3_resp1_data),
        .mul_a(l3_mul_a), .mul_b(l3_mul_b), .mul_p(l3_mul_p),
        .busy(l3_busy), .op_count(l3_op_count)
    );

    task automatic clear_inputs();
        req0_valid = 0; req0_a = 0; req0_b = 0; resp0_ready = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; resp1_ready = 0;
        l3_req0_valid = 0; l3_req0_a = 0; l3_req0_b = 0; l3_resp0_ready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        req0_valid = 1; req1_valid = 1;
        @(negedge clk); #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rst_ready: got %b%b want 00", req0_ready, req1_ready); end
        checks++; if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid: got %b%b want 00", resp0_valid, resp1_valid); end
        checks++; if (resp0_data !== 10'd0 || resp1_data !== 10'd0) begin
            errors++; $display("FAIL rst_data: got %0d/%0d want 0/0", resp0_data, resp1_data); end
        checks++; if (mul_a !== 5'd0 || mul_b !== 5'd0) begin
            errors++; $display("FAIL rst_mul: got %0d/%0d want 0/0", mul_a, mul_b); end
        checks++; if (busy !== 1'b0 || op_count !== 8'd0) begin
            errors++; $display("FAIL rst_busy_cnt: got %b/%0d want 0/0", busy, op_count); end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk); req0_valid = 1; req0_a = 31; req0_b = 31; resp0_ready = 1; #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_grant: got r0=%b r1=%b busy=%b want 1 0 0",
                                req0_ready, req1_ready, busy); end
        // Operands change after acceptance; the held values must not follow.
        @(negedge clk); req0_valid = 0; req0_a = 0; req0_b = 0; #1;
        checks++; if (mul_a !== 5'd31 || mul_b !== 5'd31) begin
            errors++; $display("FAIL single_mul: got %0d/%0d want 31/31", mul_a, mul_b); end
        checks++; if (busy !== 1'b1 || req0_ready !== 1'b0 || resp0_valid !== 1'b0) begin
            errors++; $display("FAIL single_calc: got busy=%b r0=%b v0=%b want 1 0 0",
                                busy, req0_ready, resp0_valid); end
        @(negedge clk); #1;
        checks++; if (resp0_valid !== 1'b1 || resp0_data !== 10'd961) begin
            errors++; $display("FAIL single_resp: got v=%b d=%0d want 1 961",
                                resp0_valid, resp0_data); end
        checks++; if (resp1_valid !== 1'b0) begin
            errors++; $display("FAIL single_resp1: got %b want 0", resp1_valid); end
        @(negedge clk); #1;
        checks++; if (resp0_valid !== 1'b0 || op_count !== 8'd1 || busy !== 1'b0) begin
            errors++; $display("FAIL single_done: got v=%b cnt=%0d busy=%b want 0 1 0",
                                resp0_valid, op_count, busy); end
    endtask

    task automatic test_simultaneous();
        logic e0, e1;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req0_valid = 1; req0_a = 4; req0_b = 8;
                req1_valid = 1; req1_a = 10; req1_b = 20;
                resp0_ready = 1; resp1_ready = 1;
            end
            if (c == 6) begin req0_valid = 0; req1_valid = 0; end
            #1;
            e0 = (c == 0);
            e1 = (c == 3);
            checks++; if (req0_ready !== e0 || req1_ready !== e1) begin
                errors++; $display("FAIL sim_ready c%0d: got %b%b want %b%b",
                                    c, req0_ready, req1_ready, e0, e1); end
            if (c == 2) begin
                checks++; if (resp0_valid !== 1'b1 || resp0_data !== 10'd32) begin
                    errors++; $display("FAIL sim_resp0: got v=%b d=%0d want 1 32",
                                        resp0_valid, resp0_data); end
            end
            if (c == 5) begin
                checks++; if (resp1_valid !== 1'b1 || resp1_data !== 10'd200) begin
                    errors++; $display("FAIL sim_resp1: got v=%b d=%0d want 1 200",
                                        resp1_valid, resp1_data); end
            end
            if (c == 6) begin
                checks++; if (op_count !== 8'd2) begin
                    errors++; $display("FAIL sim_count: got %0d want 2", op_count); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic e0, e1, eb;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c == 0) begin
                req0_valid = 1; req0_a = 3; req0_b = 7;
                req1_valid = 1; req1_a = 9; req1_b = 11;
                resp0_ready = 1; resp1_ready = 1;
            end
            if (c == 12) begin req0_valid = 0; req1_valid = 0; end
            #1;
            e0 = (c < 12) && (c % 6 == 0);
            e1 = (c < 12) && (c % 6 == 3);
            eb = (c < 12) && (c % 3 != 0);
            checks++; if (req0_ready !== e0 || req1_ready !== e1 || busy !== eb) begin
                errors++; $display("FAIL rr c%0d: got r=%b%b busy=%b want r=%b%b busy=%b",
                                    c, req0_ready, req1_ready, busy, e0, e1, eb); end
            if (c % 6 == 2) begin
                checks++; if (resp0_valid !== 1'b1 || resp0_data !== 10'd21) begin
                    errors++; $display("FAIL rr_resp0 c%0d: got v=%b d=%0d want 1 21",
                                        c, resp0_valid, resp0_data); end
            end
            if (c % 6 == 5) begin
                checks++; if (resp1_valid !== 1'b1 || resp1_data !== 10'd99) begin
                    errors++; $display("FAIL rr_resp1 c%0d: got v=%b d=%0d want 1 99",
                                        c, resp1_valid, resp1_data); end
            end
        end
        checks++; if (op_count !== 8'd4) begin
            errors++; $display("FAIL rr_count: got %0d want 4", op_count); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin req1_valid = 1; req1_a = 12; req1_b = 13; end
            if (c == 1) begin
                req1_valid = 0; req1_a = 1;
                req0_valid = 1; req0_a = 3; req0_b = 3; resp0_ready = 1;
            end
            if (c == 7) resp1_ready = 1;
            if (c == 9) req0_valid = 0;
            #1;
            if (c == 0) begin
                checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_grant: got r=%b%b want 01",
                                        req0_ready, req1_ready); end
            end
            if (c >= 2 && c <= 7) begin
                checks++; if (resp1_valid !== 1'b1 || resp1_data !== 10'd156 || busy !== 1'b1 ||
                              req0_ready !== 1'b0 || mul_a !== 5'd12) begin
                    errors++; $display("FAIL bp_hold c%0d: got v=%b d=%0d busy=%b r0=%b a=%0d",
                                        c, resp1_valid, resp1_data, busy, req0_ready, mul_a); end
            end
            if (c == 8) begin
                checks++; if (resp1_valid !== 1'b0 || busy !== 1'b0 || op_count !== 8'd1 ||
                              req0_ready !== 1'b1) begin
                    errors++; $display("FAIL bp_release: got v=%b busy=%b cnt=%0d r0=%b",
                                        resp1_valid, busy, op_count, req0_ready); end
            end
            if (c == 10) begin
                checks++; if (resp0_valid !== 1'b1 || resp0_data !== 10'd9 ||
                              resp1_valid !== 1'b0 || resp1_data !== 10'd156) begin
                    errors++; $display("FAIL bp_other: got v0=%b d0=%0d v1=%b d1=%0d",
                                        resp0_valid, resp0_data, resp1_valid, resp1_data); end
            end
            if (c == 11) begin
                checks++; if (op_count !== 8'd2) begin
                    errors++; $display("FAIL bp_count: got %0d want 2", op_count); end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clk); req0_valid = 1; req0_a = 31; req0_b = 31; resp0_ready = 1;
        @(negedge clk); req0_valid = 0;
        @(negedge clk);
        @(negedge clk); req0_valid = 1; req0_a = 10; req0_b = 20;
        @(negedge clk); req0_valid = 0; #1;
        checks++; if (busy !== 1'b1 || mul_a !== 5'd10 || op_count !== 8'd1) begin
            errors++; $display("FAIL ar_pre: got busy=%b a=%0d cnt=%0d want 1 10 1",
                                busy, mul_a, op_count); end
        #1; rst = 1'b1; #1;
        checks++; if (busy !== 1'b0 || mul_a !== 5'd0 || mul_b !== 5'd0 ||
                      op_count !== 8'd0) begin
            errors++; $display("FAIL ar_clear: got busy=%b a=%0d b=%0d cnt=%0d want 0",
                                busy, mul_a, mul_b, op_count); end
        checks++; if (resp0_valid !== 1'b0 || resp0_data !== 10'd0) begin
            errors++; $display("FAIL ar_resp: got v=%b d=%0d want 0 0",
                                resp0_valid, resp0_data); end
        @(negedge clk); #1;
        checks++; if (resp0_valid !== 1'b0) begin
            errors++; $display("FAIL ar_novalid: got %b want 0", resp0_valid); end
        rst = 1'b0;
        @(negedge clk);
        req0_valid = 1; req0_a = 12; req0_b = 13;
        req1_valid = 1; req1_a = 5; req1_b = 5; resp1_ready = 1; #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL ar_ptr: got r=%b%b want 10", req0_ready, req1_ready); end
        @(negedge clk); req0_valid = 0; req1_valid = 0;
        @(negedge clk); #1;
        checks++; if (resp0_valid !== 1'b1 || resp0_data !== 10'd156 || resp1_valid !== 1'b0) begin
            errors++; $display("FAIL ar_fresh: got v0=%b d0=%0d v1=%b want 1 156 0",
                                resp0_valid, resp0_data, resp1_valid); end
    endtask

    task automatic test_settle();
        logic ev;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                l3_req0_valid = 1; l3_req0_a = 31; l3_req0_b = 31; l3_resp0_ready = 1;
            end
            if (c == 1) l3_req0_valid = 0;
            #1;
            if (c == 0) begin
                checks++; if (l3_req0_ready !== 1'b1) begin
                    errors++; $display("FAIL l3_grant: got %b want 1", l3_req0_ready); end
            end
            ev = (c == 4);
            checks++; if (l3_resp0_valid !== ev) begin
                errors++; $display("FAIL l3_valid c%0d: got %b want %b", c, l3_resp0_valid, ev); end
            if (c == 4) begin
                checks++; if (l3_resp0_data !== 10'd961) begin
                    errors++; $display("FAIL l3_data: got %0d want 961", l3_resp0_data); end
            end
            if (c == 5) begin
                checks++; if (l3_op_count !== 8'd1 || l3_busy !== 1'b0) begin
                    errors++; $display("FAIL l3_done: got cnt=%0d busy=%b want 1 0",
                                        l3_op_count, l3_busy); end
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        // One op per 3 cycles: the 255th completion is visible in cycle 765,
        // the 256th in cycle 768.
        for (int c = 0; c <= 768; c++) begin
            @(negedge clk);
            req0_valid = (c <= 765); req0_a = 1; req0_b = 1; resp0_ready = 1;
            #1;
            if (c == 765) begin
                checks++; if (op_count !== 8'd255) begin
                    errors++; $display("FAIL wrap_255: got %0d want 255", op_count); end
            end
            if (c == 768) begin
                checks++; if (op_count !== 8'd0 || busy !== 1'b0) begin
                    errors++; $display("FAIL wrap_0: got cnt=%0d busy=%b want 0 0",
                                        op_count, busy); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_back_pressure();
        test_async_reset();
        test_settle();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
